// File: rtl/tone_synth_if.sv
// Control and sample bus between the tone source and its controller/consumer.
// The master drives note/volume controls; the slave returns stereo samples and status.
interface tone_synth_if #(
    parameter int DIV_W = 22
);
    logic [DIV_W-1:0] note_div_left;
    logic [DIV_W-1:0] note_div_right;
    logic             note_load;
    logic             note_on;
    logic [2:0]       vol;
    logic [15:0]      audio_left;
    logic [15:0]      audio_right;
    logic             ramp_done;
    logic             pending;

    modport master (
        output note_div_left, note_div_right, note_load, note_on, vol,
        input  audio_left, audio_right, ramp_done, pending
    );

    modport slave (
        input  note_div_left, note_div_right, note_load, note_on, vol,
        output audio_left, audio_right, ramp_done, pending
    );
endinterface

// File: rtl/tone_synth.sv
// Stereo square-wave tone source with per-channel half-period dividers and a shared
// linear attack/release envelope; all outputs are registered so they never glitch.
module tone_synth #(
    parameter int          DIV_W     = 22,
    parameter int          RAMP_CYC  = 256,
    parameter logic [15:0] RAMP_STEP = 16'h0100
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_synth_if.slave    bus
);
    localparam int                PRE_W    = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RAMP_CYC - 1);

    // Envelope target: silence when muted, else full scale shifted down by volume.
    function automatic logic [14:0] f_target(input logic on, input logic [2:0] v);
        logic [14:0] t;
        t = '0;
        if (on && (v != 3'd0)) begin
            t = 15'h7FFF >> (3'd7 - v);
        end
        return t;
    endfunction

    // One envelope step toward the target, clamped so it never overshoots.
    function automatic logic [14:0] f_step_toward(input logic [14:0] cur, input logic [14:0] tgt);
        logic [15:0] diff;
        logic [14:0] nxt;
        diff = '0;
        nxt  = tgt;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            if (diff > RAMP_STEP) nxt = cur + RAMP_STEP[14:0];
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            if (diff > RAMP_STEP) nxt = cur - RAMP_STEP[14:0];
        end
        return nxt;
    endfunction

    logic [PRE_W-1:0]  r_pre;
    logic [14:0]       r_amp;
    logic              r_done;
    logic [14:0]       w_target;
    logic              w_pre_wrap;
    logic [1:0]        w_pend;
    logic [1:0][15:0]  w_audio;

    assign w_target   = f_target(bus.note_on, bus.vol);
    assign w_pre_wrap = (r_pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_amp  <= '0;
            r_done <= 1'b1;
        end else begin
            r_pre  <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
            if (w_pre_wrap) r_amp <= f_step_toward(r_amp, w_target);
            r_done <= (r_amp == w_target);
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [DIV_W-1:0]   w_div_in;
        logic [DIV_W-1:0]   r_div_act;
        logic [DIV_W-1:0]   r_div_pend;
        logic [DIV_W-1:0]   r_cnt;
        logic               r_pend;
        logic               r_phase;
        logic signed [15:0] r_audio_p1;
        logic               w_active;
        logic               w_wrap;
        logic               w_xfer;
        logic signed [15:0] w_mag;
        logic signed [15:0] w_sample;

        assign w_div_in = (ch == 0) ? bus.note_div_left : bus.note_div_right;
        assign w_active = (r_div_act >= DIV_W'(2));
        assign w_wrap   = w_active && (r_cnt == r_div_act - DIV_W'(1));
        // A pending divisor lands only on a half-period boundary, or at once when idle.
        assign w_xfer   = r_pend && (w_wrap || !w_active);
        assign w_mag    = signed'({1'b0, r_amp});
        assign w_sample = (!w_active || (r_amp == 15'd0)) ? '0 : (r_phase ? w_mag : -w_mag);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_div_act  <= '0;
                r_div_pend <= '0;
                r_cnt      <= '0;
                r_pend     <= 1'b0;
                r_phase    <= 1'b0;
                r_audio_p1 <= '0;
            end else begin
                if (bus.note_load) r_div_pend <= w_div_in;
                r_pend <= bus.note_load | (r_pend & ~w_xfer);
                if (w_xfer) r_div_act <= r_div_pend;
                if (!w_active) begin
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt   <= r_cnt + DIV_W'(1);
                end
                // Output stage: sample registered one clock after phase/amp.
                r_audio_p1 <= w_sample;
            end
        end

        assign w_pend[ch]  = r_pend;
        assign w_audio[ch] = r_audio_p1;
    end

    assign bus.audio_left  = w_audio[0];
    assign bus.audio_right = w_audio[1];
    assign bus.ramp_done   = r_done;
    assign bus.pending     = |w_pend;
endmodule
